// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one external ALU between two requesters. The block arbitrates
// round-robin in IDLE, holds the winner's operands on the ALU inputs for one
// EXEC cycle, captures the ALU result, and pulses the winner's done in RESP.
// One operation takes 3 cycles: grant edge, capture edge, return to IDLE.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   req0/1, ctl0/1       request and 4-bit ALU control code per requester
//   a0, b0, a1, b1       32-bit operands per requester
//   gnt0/1               combinational grant; operands latched on this edge
//   done0/1              one-cycle result-valid pulse to the winner
//   res, zero, err       captured result, res==0 flag, illegal-code flag
//   busy                 state is not IDLE
//   alu_ctl/a/b          drive the shared ALU
//   alu_out, alu_zero    ALU result; alu_zero is ignored, zero comes from res
module alu_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [3:0]  ctl0,
    input  logic [3:0]  ctl1,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] res,
    output logic        zero,
    output logic        err,
    output logic        busy,
    output logic [3:0]  alu_ctl,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_out,
    input  logic        alu_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic        last_id;   // requester granted most recently
    logic        id_q;      // requester owning the in-flight operation
    logic [3:0]  ctl_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        pick1;
    logic        legal;

    // The zero flag is derived from the captured result, so the ALU's own
    // flag is deliberately left unconnected.
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero;

    // Requester 1 wins when it is alone, or when both request and requester 0
    // was served last.
    assign pick1 = req1 && (!req0 || !last_id);

    // Reset masks the grant so a request in the reset cycle cannot be taken.
    assign gnt0 = (state == IDLE) && !reset && req0 && !pick1;
    assign gnt1 = (state == IDLE) && !reset && pick1;

    // Gating with reset suppresses the pulse of an operation being discarded.
    assign done0 = (state == RESP) && !id_q && !reset;
    assign done1 = (state == RESP) &&  id_q && !reset;
    assign busy  = (state != IDLE);

    assign alu_ctl = ctl_q;
    assign alu_a   = a_q;
    assign alu_b   = b_q;

    always_comb begin
        // NOTE: a default before the case keeps this purely combinational;
        // any path that leaves legal unassigned would infer a latch.
        legal = 1'b0;
        case (ctl_q)
            4'b0000, 4'b0001, 4'b0010,
            4'b0110, 4'b0111, 4'b1100: legal = 1'b1;
            default:                   legal = 1'b0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            last_id <= 1'b1;   // pretend requester 1 went last: favours 0
            id_q    <= 1'b0;
            ctl_q   <= 4'b0000;
            a_q     <= '0;
            b_q     <= '0;
            res     <= '0;
            zero    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        state   <= EXEC;
                        id_q    <= gnt1;
                        last_id <= gnt1;
                        ctl_q   <= gnt1 ? ctl1 : ctl0;
                        a_q     <= gnt1 ? a1 : a0;
                        b_q     <= gnt1 ? b1 : b0;
                    end
                end
                EXEC: begin
                    state <= RESP;
                    if (legal) begin
                        res  <= alu_out;
                        zero <= (alu_out == 32'd0);
                        err  <= 1'b0;
                    end else begin
                        res  <= '0;
                        zero <= 1'b0;
                        err  <= 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: a behavioural ALU answers the shared ALU port,
// a table of single-requester operations is run through a common sequence,
// and hand-written sequences cover contention, dropped requests and reset.
module tb_alu_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1;
    logic [3:0]  ctl0, ctl1;
    logic [31:0] a0, b0, a1, b1;
    logic        gnt0, gnt1, done0, done1;
    logic [31:0] res;
    logic        zero, err, busy;
    logic [3:0]  alu_ctl;
    logic [31:0] alu_a, alu_b, alu_out;
    logic        alu_zero;

    int total = 0;
    int bad   = 0;

    alu_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .req1     (req1),
        .ctl0     (ctl0),
        .ctl1     (ctl1),
        .a0       (a0),
        .b0       (b0),
        .a1       (a1),
        .b1       (b1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .done0    (done0),
        .done1    (done1),
        .res      (res),
        .zero     (zero),
        .err      (err),
        .busy     (busy),
        .alu_ctl  (alu_ctl),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_out  (alu_out),
        .alu_zero (alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU. Illegal codes return a non-zero pattern so the block's
    // own zeroing of res is visible.
    function automatic logic [31:0] alu_fn(input logic [3:0] c,
                                           input logic [31:0] x,
                                           input logic [31:0] y);
        case (c)
            4'b0000: alu_fn = x & y;
            4'b0001: alu_fn = x | y;
            4'b0010: alu_fn = x + y;
            4'b0110: alu_fn = x - y;
            4'b0111: alu_fn = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'b1100: alu_fn = ~(x | y);
            default: alu_fn = 32'hDEAD_BEEF;
        endcase
    endfunction

    assign alu_out  = alu_fn(alu_ctl, alu_a, alu_b);
    assign alu_zero = (alu_out == 32'd0);

    typedef struct {
        logic        who;
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        err;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one cycle and settle away from the active edge.
    task automatic next();
        @(posedge clk);
        #2;
    endtask

    task automatic run_op(input vec_t v);
        if (v.who) begin
            req1 = 1'b1; ctl1 = v.ctl; a1 = v.a; b1 = v.b;
        end else begin
            req0 = 1'b1; ctl0 = v.ctl; a0 = v.a; b0 = v.b;
        end
        #1;
        check("op_gnt0", gnt0, !v.who);
        check("op_gnt1", gnt1, v.who);
        next();
        req0 = 1'b0;
        req1 = 1'b0;
        #1;
        check("exec_busy", busy, 1'b1);
        check("exec_gnt", {gnt0, gnt1}, 2'b00);
        check("exec_alu_ctl", alu_ctl, v.ctl);
        check("exec_alu_a", alu_a, v.a);
        check("exec_alu_b", alu_b, v.b);
        next();
        #1;
        check("resp_done", {done0, done1}, v.who ? 2'b01 : 2'b10);
        check("resp_res", res, v.res);
        check("resp_zero", zero, v.zero);
        check("resp_err", err, v.err);
        check("resp_alu_ctl_hold", alu_ctl, v.ctl);
        next();
        #1;
        check("idle_done", {done0, done1}, 2'b00);
        check("idle_busy", busy, 1'b0);
        check("idle_res_hold", res, v.res);
    endtask

    initial begin
        //          who   ctl      a             b             res           zero  err
        vecs[0] = '{1'b0, 4'b0010, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0};
        vecs[1] = '{1'b1, 4'b0110, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1'b1, 1'b0};
        vecs[2] = '{1'b0, 4'b0111, 32'd3,        32'd9,        32'd1,        1'b0, 1'b0};
        vecs[3] = '{1'b0, 4'b1100, 32'd0,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 4'b0101, 32'd1,        32'd2,        32'd0,        1'b0, 1'b1};
        vecs[5] = '{1'b0, 4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 4'b0001, 32'h00FF0000, 32'h0000FF00, 32'h00FFFF00, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 4'b0111, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0};
        vecs[8] = '{1'b0, 4'b0010, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0};

        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        ctl0 = '0; ctl1 = '0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        next();
        next();
        reset = 1'b0;
        #1;
        check("rst_gnt", {gnt0, gnt1}, 2'b00);
        check("rst_done", {done0, done1}, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_res", res, 32'd0);
        check("rst_zero", zero, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_alu_ctl", alu_ctl, 4'b0000);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);

        // Contention: both held high from reset; grants alternate starting
        // with 0 and each done carries its own requester's result.
        req0 = 1'b1; ctl0 = 4'b0010; a0 = 32'd1;  b0 = 32'd2;
        req1 = 1'b1; ctl1 = 4'b0110; a1 = 32'd10; b1 = 32'd20;
        for (int i = 0; i < 4; i++) begin
            logic exp1;
            exp1 = i[0];
            #1;
            check("rr_gnt", {gnt0, gnt1}, exp1 ? 2'b01 : 2'b10);
            next();
            #1;
            check("rr_exec_gnt", {gnt0, gnt1}, 2'b00);
            next();
            #1;
            check("rr_done", {done0, done1}, exp1 ? 2'b01 : 2'b10);
            check("rr_res", res, exp1 ? 32'hFFFFFFF6 : 32'd3);
            next();
        end
        req0 = 1'b0;
        req1 = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i]);
        end

        // A request raised while busy and dropped before IDLE is never granted.
        req0 = 1'b1; ctl0 = 4'b0010; a0 = 32'd4; b0 = 32'd4;
        #1;
        check("drop_gnt0", gnt0, 1'b1);
        next();
        req0 = 1'b0;
        req1 = 1'b1; ctl1 = 4'b0001; a1 = 32'd1; b1 = 32'd2;
        next();
        req1 = 1'b0;
        #1;
        check("drop_resp_res", res, 32'd8);
        next();
        #1;
        check("drop_idle_gnt", {gnt0, gnt1}, 2'b00);
        next();
        #1;
        check("drop_busy", busy, 1'b0);

        // Reset during EXEC discards the operation; reset also masks a
        // request in the same cycle; req1 is then granted at once.
        req0 = 1'b1; ctl0 = 4'b0010; a0 = 32'd5; b0 = 32'd7;
        #1;
        check("rexec_gnt0", gnt0, 1'b1);
        next();
        req0 = 1'b0;
        reset = 1'b1;
        #1;
        check("rexec_busy_pre", busy, 1'b1);
        next();
        req0 = 1'b1;
        #1;
        check("rexec_busy", busy, 1'b0);
        check("rexec_done", {done0, done1}, 2'b00);
        check("rexec_res", res, 32'd0);
        check("rexec_alu_a", alu_a, 32'd0);
        check("rst_override_gnt", {gnt0, gnt1}, 2'b00);
        next();
        #1;
        check("rexec_no_late_done", {done0, done1}, 2'b00);
        reset = 1'b0;
        req0 = 1'b0;
        req1 = 1'b1; ctl1 = 4'b0001; a1 = 32'h0F; b1 = 32'hF0;
        #1;
        check("post_rst_gnt1", {gnt0, gnt1}, 2'b01);
        next();
        req1 = 1'b0;
        next();
        #1;
        check("post_rst_done1", {done0, done1}, 2'b01);
        check("post_rst_res", res, 32'hFF);
        next();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
- req0, req1  in  1  request from requester 0 / 1; held high with operands stable until granted.
- ctl0, ctl1  in  4  ALU control code from requester 0 / 1.
- a0, b0, a1, b1  in  32  operands from requester 0 / 1.
- gnt0, gnt1  out  1  combinational grant; operands are captured at the rising edge where gnt is high.
- done0, done1  out  1  one-cycle result-valid pulse to requester 0 / 1.
- res  out  32  result, valid while done0 or done1 is high.
- zero  out  1  res equals 0, valid with done.
- err  out  1  captured ctl was illegal, valid with done.
- busy  out  1  state is not IDLE.
- alu_ctl  out  4  to the shared ALU control input.
- alu_a, alu_b  out  32  to the shared ALU operand inputs.
- alu_out  in  32  ALU result.
- alu_zero  in  1  ALU zero flag; sampled but not used (see REQ-010).

Function
REQ-003 The FSM SHALL have three states, IDLE, EXEC and RESP, with these transitions:
- IDLE -> EXEC on any grant.
- EXEC -> RESP unconditionally.
- RESP -> IDLE unconditionally.
REQ-004 In IDLE, the block SHALL raise exactly one of gnt0/gnt1 whenever req0 or req1 is high; gnt SHALL be 0 in EXEC and RESP.
REQ-005 Arbitration SHALL be round-robin:
- If only one requester is active, that requester is granted.
- If both are active, the requester not granted last is granted.
- The last-grant pointer updates only on a grant; after reset it favours requester 0.
REQ-006 At the granting edge, the block SHALL latch ctl, a, b and the requester id into internal registers.
REQ-007 alu_ctl, alu_a and alu_b SHALL be driven from those registers, stay constant for all of EXEC, and hold their last values in RESP and IDLE.
REQ-008 At the EXEC->RESP edge, the block SHALL capture alu_out into res.
REQ-009 Legal ctl codes SHALL be 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
REQ-010 zero SHALL be computed from the captured res (res == 0), not from alu_zero.
REQ-011 For an illegal ctl code, the block SHALL still run EXEC but SHALL capture res=0, zero=0, err=1; for a legal code err=0.
REQ-012 In RESP, done of the latched requester id SHALL be 1 for exactly one cycle; the other done SHALL be 0.
REQ-013 res, zero and err SHALL hold their values until the next capture.
REQ-014 Latency: the grant edge is cycle 0, done is high in cycle 2, and the next grant is possible in cycle 3; peak throughput is one operation per 3 cycles.
REQ-015 Boundary conditions:
- A req dropped before being granted SHALL produce no grant.
- A req held high through RESP SHALL be re-arbitrated in IDLE under REQ-005.
- A request with both requesters active SHALL be granted within 2 operations (starvation-free).

Reset
REQ-016 Reset values: state IDLE, gnt0=gnt1=0, done0=done1=0, busy=0, res=0, zero=0, err=0, alu_ctl=0000, alu_a=alu_b=0, pointer favours requester 0.
REQ-017 Reset asserted in EXEC or RESP SHALL discard the in-flight operation: no done pulse, and state is IDLE at the next edge.
REQ-018 Reset SHALL override all requests in the same cycle.

Verification
REQ-019 Single op: req0, ctl0=0010, a0=5, b0=7 -> gnt0 in cycle 0; alu_ctl=0010 in EXEC; done0 in cycle 2 with res=12, zero=0, err=0.
REQ-020 Contention: req0 and req1 held high continuously after reset -> grants alternate 0,1,0,1; each done matches its own operands; done pulses are 3 cycles apart.
REQ-021 Zero and SUB: ctl1=0110, a1=b1=0xFFFFFFFF -> done1 with res=0, zero=1.
REQ-022 SLT and NOR:
- ctl0=0111, a0=3, b0=9 -> res=1.
- ctl0=1100, a0=b0=0 -> res=0xFFFFFFFF, zero=0.
REQ-023 Illegal code: ctl0=0101 -> done0 with res=0, zero=0, err=1; the following legal op returns err=0.
REQ-024 Reset in EXEC -> no done0/done1 pulse; busy=0, res=0 after the reset edge; a subsequent req1 is granted on its first IDLE cycle.
